// File: rtl/counter_checker.sv
// Passive monitor for an 8-bit load/increment counter: checks C(n+1) = LOAD ? VALUE : C+1,
// counts violations (saturating) and captures the first failing expected/observed pair.
module counter_checker #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ERR_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 ENABLE,
  input  logic                 CLEAR,
  input  logic                 DUT_RESET,
  input  logic                 LOAD,
  input  logic [WIDTH-1:0]     VALUE,
  input  logic [WIDTH-1:0]     C,
  output logic                 LOCKED,
  output logic                 MISMATCH,
  output logic                 ERROR,
  output logic [ERR_WIDTH-1:0] ERR_COUNT,
  output logic [WIDTH-1:0]     FIRST_EXP,
  output logic [WIDTH-1:0]     FIRST_OBS
);

  typedef enum logic [1:0] {StIdle, StArm, StCheck} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     s_c_q, s_c_d;
  logic                 s_load_q, s_load_d;
  logic [WIDTH-1:0]     s_val_q, s_val_d;
  logic                 mismatch_q, mismatch_d;
  logic                 error_q, error_d;
  logic [ERR_WIDTH-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0]     first_exp_q, first_exp_d;
  logic [WIDTH-1:0]     first_obs_q, first_obs_d;

  logic                 active;
  logic                 compare;
  logic [WIDTH-1:0]     exp_val;

  // Tracking stays valid only while enabled and the monitored counter is out of reset.
  assign active  = ENABLE && !DUT_RESET;
  assign compare = active && (state_q == StCheck);
  assign exp_val = s_load_q ? s_val_q : s_c_q + WIDTH'(1);

  always_comb begin
    state_d = StIdle;
    if (active) begin
      unique case (state_q)
        StIdle:  state_d = StArm;
        StArm:   state_d = StCheck;
        StCheck: state_d = StCheck;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    s_c_d       = C;
    s_load_d    = LOAD;
    s_val_d     = VALUE;
    mismatch_d  = compare && (C != exp_val);
    error_d     = error_q;
    err_count_d = err_count_q;
    first_exp_d = first_exp_q;
    first_obs_d = first_obs_q;
    // CLEAR wins over a same-edge mismatch; MISMATCH itself still reports the compare.
    if (CLEAR) begin
      error_d     = 1'b0;
      err_count_d = '0;
      first_exp_d = '0;
      first_obs_d = '0;
    end else if (mismatch_d) begin
      if (err_count_q != '1) begin
        err_count_d = err_count_q + ERR_WIDTH'(1);
      end
      if (!error_q) begin
        error_d     = 1'b1;
        first_exp_d = exp_val;
        first_obs_d = C;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      s_c_q       <= '0;
      s_load_q    <= 1'b0;
      s_val_q     <= '0;
      mismatch_q  <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
      first_exp_q <= '0;
      first_obs_q <= '0;
    end else begin
      state_q     <= state_d;
      s_c_q       <= s_c_d;
      s_load_q    <= s_load_d;
      s_val_q     <= s_val_d;
      mismatch_q  <= mismatch_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
      first_exp_q <= first_exp_d;
      first_obs_q <= first_obs_d;
    end
  end

  assign LOCKED    = (state_q == StCheck);
  assign MISMATCH  = mismatch_q;
  assign ERROR     = error_q;
  assign ERR_COUNT = err_count_q;
  assign FIRST_EXP = first_exp_q;
  assign FIRST_OBS = first_obs_q;

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker: directed scenarios plus randomized traffic, all
// outputs compared every cycle against an arithmetic reference model.
module tb_counter_checker;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       clear;
  logic       dut_reset;
  logic       load;
  logic [7:0] value;
  logic [7:0] c_in;
  logic       locked;
  logic       mismatch;
  logic       error;
  logic [7:0] err_count;
  logic [7:0] first_exp;
  logic [7:0] first_obs;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_run;       // consecutive tracking edges since (re)start
  int m_prev_c;
  int m_prev_load;
  int m_prev_val;
  int m_mis;
  int m_err;
  int m_cnt;
  int m_fexp;
  int m_fobs;

  int cur;         // value the emulated counter presents next

  counter_checker #(
    .WIDTH     (8),
    .ERR_WIDTH (8)
  ) u_dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .ENABLE    (enable),
    .CLEAR     (clear),
    .DUT_RESET (dut_reset),
    .LOAD      (load),
    .VALUE     (value),
    .C         (c_in),
    .LOCKED    (locked),
    .MISMATCH  (mismatch),
    .ERROR     (error),
    .ERR_COUNT (err_count),
    .FIRST_EXP (first_exp),
    .FIRST_OBS (first_obs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_run = 0; m_prev_c = 0; m_prev_load = 0; m_prev_val = 0;
    m_mis = 0; m_err = 0; m_cnt = 0; m_fexp = 0; m_fobs = 0;
  endtask

  // One clock edge of the specified behaviour, on the inputs currently driven.
  task automatic model_edge();
    bit act;
    int expv;
    act   = enable && !dut_reset;
    expv  = m_prev_load ? m_prev_val : (m_prev_c + 1) % 256;
    m_mis = (act && m_run >= 2 && int'(c_in) != expv) ? 1 : 0;
    if (clear) begin
      m_err = 0; m_cnt = 0; m_fexp = 0; m_fobs = 0;
    end else if (m_mis == 1) begin
      if (m_cnt < 255) m_cnt++;
      if (m_err == 0) begin
        m_err = 1; m_fexp = expv; m_fobs = int'(c_in);
      end
    end
    m_run       = act ? ((m_run < 2) ? m_run + 1 : 2) : 0;
    m_prev_c    = int'(c_in);
    m_prev_load = int'(load);
    m_prev_val  = int'(value);
  endtask

  task automatic check_all();
    check("locked",    int'(locked),    (m_run >= 2) ? 1 : 0);
    check("mismatch",  int'(mismatch),  m_mis);
    check("error",     int'(error),     m_err);
    check("err_count", int'(err_count), m_cnt);
    check("first_exp", int'(first_exp), m_fexp);
    check("first_obs", int'(first_obs), m_fobs);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Present C, LOAD, VALUE for one edge; the emulated counter follows what it presented.
  task automatic drive(input int c, input bit ld, input int val);
    c_in  = 8'(c);
    load  = ld;
    value = 8'(val);
    cyc();
    cur   = ld ? val : (c + 1) % 256;
    load  = 1'b0;
  endtask

  task automatic count_ok(input int n);
    for (int i = 0; i < n; i++) drive(cur, 1'b0, 0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; dut_reset = 1'b0;
    load = 1'b0; value = 8'h00; c_in = 8'h00; cur = 0;
    model_reset();
    #12;
    check("reset_locked", int'(locked), 0);
    check("reset_err_count", int'(err_count), 0);
    check_all();
    rst_n = 1'b1;
    #2;

    // Free-running counter through the wrap
    enable = 1'b1;
    count_ok(2);
    check("locked_2nd_edge", int'(locked), 1);
    count_ok(298);
    check("run_err_count", int'(err_count), 0);

    // LOAD honoured, then a wrong value after a LOAD
    drive(cur, 1'b1, 8'h10);
    drive(8'h10, 1'b1, 8'h5A);
    drive(8'h5A, 1'b1, 8'h10);
    check("load_ok_mismatch", int'(mismatch), 0);
    drive(8'h10, 1'b1, 8'h5A);
    drive(8'h5B, 1'b0, 0);
    check("load_bad_mismatch", int'(mismatch), 1);
    check("load_bad_first_exp", int'(first_exp), 8'h5A);
    check("load_bad_first_obs", int'(first_obs), 8'h5B);
    check("load_bad_count", int'(err_count), 1);
    count_ok(1);
    check("pulse_one_cycle", int'(mismatch), 0);

    // Two skips after a clear
    clear = 1'b1;
    count_ok(1);
    clear = 1'b0;
    drive(cur, 1'b1, 8'h20);
    drive(8'h20, 1'b0, 0);
    drive(8'h22, 1'b0, 0);
    drive(8'h23, 1'b0, 0);
    drive(8'h25, 1'b0, 0);
    check("skip_count", int'(err_count), 2);
    check("skip_first_exp", int'(first_exp), 8'h21);
    check("skip_first_obs", int'(first_obs), 8'h22);

    // Saturation, then CLEAR keeps the lock
    for (int i = 0; i < 300; i++) drive((cur + 1) % 256, 1'b0, 0);
    check("sat_count", int'(err_count), 8'hFF);
    clear = 1'b1;
    drive(cur, 1'b0, 0);
    clear = 1'b0;
    check("clear_error", int'(error), 0);
    check("clear_count", int'(err_count), 0);
    check("clear_locked", int'(locked), 1);

    // Monitored counter reset mid-count
    drive(cur, 1'b1, 8'h30);
    count_ok(7);
    dut_reset = 1'b1;
    drive(8'h00, 1'b0, 0);
    check("dutrst_locked", int'(locked), 0);
    check("dutrst_mismatch", int'(mismatch), 0);
    drive(8'h00, 1'b0, 0);
    dut_reset = 1'b0;
    cur = 0;
    count_ok(1);
    check("dutrst_arm", int'(locked), 0);
    count_ok(1);
    check("dutrst_relock", int'(locked), 1);
    count_ok(20);
    check("dutrst_count", int'(err_count), 0);

    // Asynchronous reset between edges, then disabled
    drive((cur + 3) % 256, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_locked", int'(locked), 0);
    check("arst_error", int'(error), 0);
    check("arst_count", int'(err_count), 0);
    check_all();
    #2;
    rst_n  = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) drive((cur + 7) % 256, 1'b0, 0);
    check("disabled_locked", int'(locked), 0);
    check("disabled_count", int'(err_count), 0);

    // Randomized traffic
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int cv;
      bit ld;
      enable    = ($urandom_range(0, 63) != 0);
      dut_reset = ($urandom_range(0, 63) == 0);
      clear     = ($urandom_range(0, 99) == 0);
      ld        = ($urandom_range(0, 5) == 0);
      cv        = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : cur;
      if (dut_reset) cv = 0;
      drive(cv, ld, int'($urandom_range(0, 255)));
    end
    dut_reset = 1'b0;
    clear     = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
